// File: rtl/traceback_direction_reader_if.sv
// Read-port and step-stream signals between the traceback reader, the
// direction RAM and the alignment-output stage.
interface traceback_direction_reader_if #(
  parameter int N = 128
);
  localparam int BitAddr     = $clog2(N+1);
  localparam int addr_lenght = $clog2(((N+1)*(N+1))-1);

  logic                 rd_en;
  logic [addr_lenght:0] rd_addr;
  logic [2:0]           rd_symbol;
  logic                 step_valid;
  logic                 step_ready;
  logic [2:0]           step_dir;
  logic [BitAddr:0]     step_i;
  logic [BitAddr:0]     step_j;

  modport master (
    output rd_en, rd_addr, step_valid, step_dir, step_i, step_j,
    input  rd_symbol, step_ready
  );

  modport slave (
    input  rd_en, rd_addr, step_valid, step_dir, step_i, step_j,
    output rd_symbol, step_ready
  );
endinterface

// File: rtl/traceback_direction_reader.sv
// Walks the NW direction RAM from (len_i, len_j) back to (0,0), one read and one
// emitted step per cell. Optional step counter port: TRACE_STEP_COUNT_EN.
module traceback_direction_reader #(
  parameter int N           = 128,
  parameter int BitAddr     = $clog2(N+1),
  parameter int addr_lenght = $clog2(((N+1)*(N+1))-1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [BitAddr:0]             len_i,
  input  logic [BitAddr:0]             len_j,
  traceback_direction_reader_if.master bus,
  output logic                         busy,
  output logic                         done,
  output logic                         err
`ifdef TRACE_STEP_COUNT_EN
  ,
  output logic [BitAddr+1:0]           step_count
`endif
);

  localparam int IW = BitAddr + 1;
  localparam int AW = addr_lenght + 1;
  localparam logic [IW-1:0] NMAX = IW'(N);
  localparam logic [AW-1:0] ROW  = AW'(N + 1);

  localparam logic [2:0] DIAG = 3'b001;
  localparam logic [2:0] UP   = 3'b010;
  localparam logic [2:0] LEFT = 3'b100;

  typedef enum logic [2:0] {IDLE, READ, WAIT, EMIT, DONE, ERR} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   cur_i, cur_j, cur_i_nx, cur_j_nx;
  logic [2:0]      sym_q;
  logic            legal, hs;
  logic            rd_en_q, rd_en_nx;
  logic [AW-1:0]   rd_addr_q, rd_addr_nx;
  logic            err_q;
`ifdef TRACE_STEP_COUNT_EN
  logic [IW:0]     count_q;
`endif

  assign hs = (state == EMIT) && bus.step_ready;

  always_comb begin
    legal = 1'b0;
    case (bus.rd_symbol)
      DIAG:    legal = (cur_i != '0) && (cur_j != '0);
      UP:      legal = (cur_i != '0);
      LEFT:    legal = (cur_j != '0);
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_i     <= '0;
      cur_j     <= '0;
      sym_q     <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      err_q     <= 1'b0;
`ifdef TRACE_STEP_COUNT_EN
      count_q   <= '0;
`endif
    end else begin
      state     <= state_nx;
      cur_i     <= cur_i_nx;
      cur_j     <= cur_j_nx;
      rd_en_q   <= rd_en_nx;
      rd_addr_q <= rd_addr_nx;
      if (state == WAIT)
        sym_q <= bus.rd_symbol;
      if (state_nx == ERR)
        err_q <= 1'b1;
      else if (state == IDLE && start)
        err_q <= 1'b0;
`ifdef TRACE_STEP_COUNT_EN
      if (state == IDLE && start)
        count_q <= '0;
      else if (hs)
        count_q <= count_q + 1'b1;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    cur_i_nx = cur_i;
    cur_j_nx = cur_j;
    case (state)
      IDLE: begin
        if (start) begin
          cur_i_nx = len_i;
          cur_j_nx = len_j;
          if (len_i > NMAX || len_j > NMAX)
            state_nx = ERR;
          else if (len_i == '0 && len_j == '0)
            state_nx = DONE;
          else
            state_nx = READ;
        end
      end
      READ: state_nx = WAIT;
      WAIT: state_nx = legal ? EMIT : ERR;
      EMIT: begin
        if (hs) begin
          case (sym_q)
            DIAG: begin
              cur_i_nx = cur_i - 1'b1;
              cur_j_nx = cur_j - 1'b1;
            end
            UP:      cur_i_nx = cur_i - 1'b1;
            LEFT:    cur_j_nx = cur_j - 1'b1;
            default: ;
          endcase
          state_nx = (cur_i_nx == '0 && cur_j_nx == '0) ? DONE : READ;
        end
      end
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Read strobe and address are registered from the next-state view so the RAM
  // sees them during the READ cycle itself.
  always_comb begin
    rd_en_nx       = (state_nx == READ);
    rd_addr_nx     = rd_en_nx ? (AW'(cur_j_nx) + ROW * AW'(cur_i_nx)) : '0;
    busy           = (state == READ) || (state == WAIT) || (state == EMIT);
    done           = (state == DONE);
    err            = err_q;
    bus.rd_en      = rd_en_q;
    bus.rd_addr    = rd_addr_q;
    bus.step_valid = (state == EMIT);
    bus.step_dir   = (state == EMIT) ? sym_q : '0;
    bus.step_i     = (state == EMIT) ? cur_i : '0;
    bus.step_j     = (state == EMIT) ? cur_j : '0;
  end

`ifdef TRACE_STEP_COUNT_EN
  assign step_count = count_q;
`endif

endmodule

// File: tb/tb_traceback_direction_reader.sv
// Randomized bench for traceback_direction_reader (N=4) against a cell-walk
// reference model with a synchronous RAM model.
module tb_traceback_direction_reader;
  localparam int N     = 4;
  localparam int CELLS = (N+1)*(N+1);

  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] len_i, len_j;
  logic       busy, done, err;
`ifdef TRACE_STEP_COUNT_EN
  logic [4:0] step_count;
`endif

  traceback_direction_reader_if #(.N(N)) bus ();

  traceback_direction_reader #(.N(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .len_i (len_i),
    .len_j (len_j),
    .bus   (bus),
    .busy  (busy),
    .done  (done),
    .err   (err)
`ifdef TRACE_STEP_COUNT_EN
    ,
    .step_count (step_count)
`endif
  );

  always #5 clk = ~clk;

  logic [2:0] ram [CELLS];

  always @(posedge clk) begin
    if (rst)
      bus.rd_symbol <= 3'b000;
    else if (bus.rd_en)
      bus.rd_symbol <= (int'(bus.rd_addr) < CELLS) ? ram[int'(bus.rd_addr)] : 3'b000;
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int pack_step(input int d, input int i, input int j);
    return d*256 + i*16 + j;
  endfunction

  int exp_addr[$];
  int exp_step[$];
  int exp_term;

  // Walk the matrix cell by cell: each visited cell is read; a legal single-hot
  // move becomes a step, anything else terminates with an error.
  task automatic build_model(input int li, input int lj);
    int i, j, a, s;
    exp_addr.delete();
    exp_step.delete();
    exp_term = 1;
    if (li > N || lj > N) begin
      exp_term = 2;
      return;
    end
    i = li;
    j = lj;
    while (i != 0 || j != 0) begin
      a = j + (N+1)*i;
      exp_addr.push_back(a);
      s = int'(ram[a]);
      if (s == 1 && i > 0 && j > 0) begin
        exp_step.push_back(pack_step(s, i, j)); i--; j--;
      end else if (s == 2 && i > 0) begin
        exp_step.push_back(pack_step(s, i, j)); i--;
      end else if (s == 4 && j > 0) begin
        exp_step.push_back(pack_step(s, i, j)); j--;
      end else begin
        exp_term = 2;
        break;
      end
    end
  endtask

  task automatic clear_ram();
    for (int k = 0; k < CELLS; k++) ram[k] = 3'b000;
  endtask

  task automatic random_ram();
    int r;
    for (int k = 0; k < CELLS; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 3)      ram[k] = 3'b001;
      else if (r < 6) ram[k] = 3'b010;
      else if (r < 9) ram[k] = 3'b100;
      else            ram[k] = 3'($urandom_range(0, 7));
    end
  endtask

  // mode 0: ready always high; 1: random ready; 2: first step stalled 5 cycles
  task automatic run_trav(input int li, input int lj, input int mode);
    int cyc, last_rd, last_hs, held, stall_cnt, cur, n_steps, n_reads, term, exp_end;
    bit stalled, rdy, in_range;
    build_model(li, lj);
    n_steps  = exp_step.size();
    n_reads  = exp_addr.size();
    in_range = (li <= N && lj <= N);
    if (!in_range)         exp_end = 1;
    else if (exp_term == 1) exp_end = 3*n_steps + 1;
    else                    exp_end = 3*n_reads;
    len_i = 4'(li);
    len_j = 4'(lj);
    start = 1'b1;
    bus.step_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    last_rd = -1; last_hs = -1; stalled = 0; stall_cnt = 0; term = 0; held = 0;
    for (cyc = 1; cyc <= 200; cyc++) begin
      if (cyc == 1 && in_range) check_eq("err_clr", int'(err), 0);
      if (cyc == 1 && n_reads > 0) check_eq("lat_rd", int'(bus.rd_en), 1);
      if (bus.rd_en) begin
        if (exp_addr.size() == 0) check_eq("extra_rd", int'(bus.rd_addr), -1);
        else check_eq("rd_addr", int'(bus.rd_addr), exp_addr.pop_front());
        if (mode == 0 && last_rd >= 0) check_eq("rd_gap", cyc - last_rd, 3);
        last_rd = cyc;
      end
      if (bus.step_valid) begin
        cur = pack_step(int'(bus.step_dir), int'(bus.step_i), int'(bus.step_j));
        check_eq("emit_no_rd", int'(bus.rd_en), 0);
        if (stalled) check_eq("hold", cur, held);
        if (mode == 0)      rdy = 1'b1;
        else if (mode == 1) rdy = 1'($urandom_range(0, 1));
        else                rdy = (stall_cnt >= 5);
        if (rdy) begin
          stalled = 0;
          if (exp_step.size() == 0) check_eq("extra_step", cur, -1);
          else check_eq("step", cur, exp_step.pop_front());
          last_hs = cyc;
        end else begin
          stalled = 1;
          held = cur;
          stall_cnt++;
        end
        bus.step_ready = rdy;
      end else begin
        bus.step_ready = 1'($urandom_range(0, 1));
      end
      if (done || err) begin
        term = (done && err) ? 3 : (done ? 1 : 2);
        break;
      end
      @(negedge clk);
    end
    if (term == 0) begin
      check_eq("timeout", cyc, -1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end else begin
      check_eq("term", term, exp_term);
      check_eq("busy_end", int'(busy), 0);
      if (mode == 0) check_eq("end_cyc", cyc, exp_end);
      if (term == 1 && last_hs >= 0) check_eq("done_lat", cyc - last_hs, 1);
      check_eq("rds_left", exp_addr.size(), 0);
      check_eq("steps_left", exp_step.size(), 0);
`ifdef TRACE_STEP_COUNT_EN
      check_eq("count", int'(step_count), n_steps);
`endif
      @(negedge clk);
      check_eq("done_pulse", int'(done), 0);
      check_eq("err_sticky", int'(err), (exp_term == 2) ? 1 : 0);
`ifdef TRACE_STEP_COUNT_EN
      check_eq("count_hold", int'(step_count), n_steps);
`endif
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rd_en"}, int'(bus.rd_en), 0);
    check_eq({tag, "_rd_addr"}, int'(bus.rd_addr), 0);
    check_eq({tag, "_valid"}, int'(bus.step_valid), 0);
    check_eq({tag, "_step"}, pack_step(int'(bus.step_dir), int'(bus.step_i), int'(bus.step_j)), 0);
    check_eq({tag, "_busy"}, int'(busy), 0);
    check_eq({tag, "_done"}, int'(done), 0);
    check_eq({tag, "_err"}, int'(err), 0);
`ifdef TRACE_STEP_COUNT_EN
    check_eq({tag, "_count"}, int'(step_count), 0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    len_i = '0;
    len_j = '0;
    bus.step_ready = 1'b0;
    clear_ram();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Diagonal, row-0 and column-0 walks
    ram[12] = 3'b001; ram[6] = 3'b001;
    run_trav(2, 2, 0);
    clear_ram();
    ram[3] = 3'b100; ram[2] = 3'b100; ram[1] = 3'b100;
    run_trav(0, 3, 0);
    clear_ram();
    ram[15] = 3'b010; ram[10] = 3'b010; ram[5] = 3'b010;
    run_trav(3, 0, 0);

    // Backpressure on the first step
    clear_ram();
    ram[12] = 3'b001; ram[6] = 3'b001;
    run_trav(2, 2, 2);

    // Illegal symbols, then recovery clears err
    ram[6] = 3'b000;
    run_trav(1, 1, 0);
    ram[5] = 3'b100;
    run_trav(1, 0, 0);
    ram[6] = 3'b001;
    run_trav(2, 2, 0);

    run_trav(0, 0, 0);
    run_trav(5, 1, 0);
    run_trav(1, 5, 0);
    ram[20] = 3'b010; ram[15] = 3'b010; ram[10] = 3'b010; ram[5] = 3'b010;
    run_trav(4, 0, 1);

    for (int t = 0; t < 40; t++) begin
      random_ram();
      run_trav(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), int'($urandom_range(0, 2)));
    end

    // Reset while a step is being offered
    clear_ram();
    ram[12] = 3'b001; ram[6] = 3'b001;
    len_i = 4'd2; len_j = 4'd2; start = 1'b1; bus.step_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20 && !bus.step_valid; k++) @(negedge clk);
    check_eq("emit_reached", int'(bus.step_valid), 1);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("rst_mid");
    rst = 1'b0;

    // Start coincident with reset is dropped
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check_eq("rst_wins_busy", int'(busy), 0);
    check_eq("rst_wins_rd", int'(bus.rd_en), 0);

    run_trav(2, 2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
